// File: rtl/serial_sum_collector.sv
// serial_sum_collector: assembles LSB-first serial adder output into a word with final carry and valid/ready handoff
module serial_sum_collector #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sum,
  input  logic             carry,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             out_valid,
  output logic             busy,
  output logic             err
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic             co;
  logic             er;
  logic             take;
  logic             bad_start;
  // a frame begins from IDLE, or from HOLD when the held word is accepted in the same cycle
  always_comb begin
    take      = start && (state == IDLE || (state == HOLD && out_ready));
    bad_start = start && (state == COLLECT || (state == HOLD && !out_ready));
  end
  // FSM, shift register, counter and sticky error; bits enter at the MSB so bit 0 lands at result[0]
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      co    <= 1'b0;
      er    <= 1'b0;
    end else begin
      if (take) begin
        state <= COLLECT;
        cnt   <= CW'(1);
        sr    <= {sum, sr[WIDTH-1:1]};
      end else if (state == COLLECT) begin
        sr    <= {sum, sr[WIDTH-1:1]};
        cnt   <= (cnt == LAST) ? '0 : cnt + CW'(1);
        state <= (cnt == LAST) ? HOLD : COLLECT;
        co    <= (cnt == LAST) ? carry : co;
      end else if (state == HOLD && out_ready) begin
        state <= IDLE;
      end
      if (bad_start) er <= 1'b1;
    end
  end
  assign result    = sr;
  assign carry_out = co;
  assign out_valid = (state == HOLD);
  assign busy      = (state == COLLECT);
  assign err       = er;
endmodule

// File: tb/tb_serial_sum_collector.sv
// tb_serial_sum_collector: vector table, corner sequences and randomized run against an arithmetic model
module tb_serial_sum_collector;
  logic       clk = 1'b0;
  logic       rst, start, sum, carry, out_ready;
  logic [7:0] result;
  logic       carry_out, out_valid, busy, err;
  int         errors = 0;
  int         checks = 0;

  serial_sum_collector #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sum(sum), .carry(carry),
    .out_ready(out_ready), .result(result), .carry_out(carry_out),
    .out_valid(out_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_r;
    logic       exp_c;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // drive one 8-bit frame; r0 is out_ready during bit 0, dup is a bit index that also carries a stray start
  task automatic run_frame(input logic [7:0] w, input logic c, input logic r0, input int dup);
    for (int i = 0; i < 8; i++) begin
      start     = (i == 0) || (i == dup);
      sum       = w[i];
      carry     = (i == 7) ? c : ~c;
      out_ready = (i == 0) ? r0 : 1'b0;
      step();
      if (i == 6) check("not_valid_before_N+8", 32'(out_valid), 0);
      if (i == 0) check("busy_after_start", 32'(busy), 1);
    end
    start = 1'b0;
    sum   = 1'b0;
    carry = 1'b0;
    check("valid_at_N+8", 32'(out_valid), 1);
    check("busy_low_in_hold", 32'(busy), 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_result"}, 32'(result), 0);
    check({name, "_carry"}, 32'(carry_out), 0);
    check({name, "_valid"}, 32'(out_valid), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_err"}, 32'(err), 0);
  endtask

  initial begin
    vec_t       vecs[7];
    logic [8:0] s;
    logic [7:0] held;
    int         mk;
    logic       mh, mc, merr, r_rst;
    logic [7:0] macc, mword;
    vecs[0] = '{8'h5A, 8'h3C, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{8'h01, 8'h02, 8'h03, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vecs[4] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
    vecs[5] = '{8'h12, 8'h00, 8'h12, 1'b0};
    vecs[6] = '{8'hC8, 8'h64, 8'h2C, 1'b1};
    rst = 1'b1; start = 1'b1; sum = 1'b1; carry = 1'b1; out_ready = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0; start = 1'b0;
    for (int v = 0; v < 7; v++) begin
      s = 9'(vecs[v].a) + 9'(vecs[v].b);
      run_frame(s[7:0], s[8], 1'b0, -1);
      check("vec_result", 32'(result), 32'(vecs[v].exp_r));
      check("vec_carry", 32'(carry_out), 32'(vecs[v].exp_c));
      check("vec_err", 32'(err), 0);
      out_ready = 1'b1;
      step();
      check("vec_valid_drop", 32'(out_valid), 0);
      out_ready = 1'b0;
    end
    run_frame(8'h96, 1'b0, 1'b0, -1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_result", 32'(result), 32'h96);
      check("bp_carry", 32'(carry_out), 0);
      check("bp_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    step();
    check("bp_valid_drop", 32'(out_valid), 0);
    out_ready = 1'b0;
    run_frame(8'hE7, 1'b1, 1'b0, -1);
    run_frame(8'h03, 1'b0, 1'b1, -1);
    check("b2b_result", 32'(result), 32'h03);
    check("b2b_carry", 32'(carry_out), 0);
    check("b2b_err", 32'(err), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    run_frame(8'h96, 1'b0, 1'b0, 3);
    check("collect_start_result", 32'(result), 32'h96);
    check("collect_start_err", 32'(err), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("err_cleared", 32'(err), 0);
    run_frame(8'h5A, 1'b1, 1'b0, -1);
    held = result;
    start = 1'b1; sum = ~sum;
    step();
    start = 1'b0;
    check("hold_start_result", 32'(result), 32'h5A);
    check("hold_start_held", 32'(result), 32'(held));
    check("hold_start_carry", 32'(carry_out), 1);
    check("hold_start_valid", 32'(out_valid), 1);
    check("hold_start_busy", 32'(busy), 0);
    check("hold_start_err", 32'(err), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start = (i == 0); sum = 1'b1; carry = 1'b1;
      step();
    end
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check_all_zero("midframe_reset");
    run_frame(8'h12, 1'b0, 1'b0, -1);
    check("after_reset_result", 32'(result), 32'h12);
    check("after_reset_carry", 32'(carry_out), 0);
    rst = 1'b1;
    step();
    mk = 0; mh = 1'b0; mc = 1'b0; merr = 1'b0; macc = '0; mword = '0;
    for (int t = 0; t < 3000; t++) begin
      r_rst     = ($urandom_range(0, 199) == 0);
      rst       = r_rst;
      start     = ($urandom_range(0, 5) == 0);
      sum       = 1'($urandom);
      carry     = 1'($urandom);
      out_ready = 1'($urandom);
      if (r_rst) begin
        mk = 0; mh = 1'b0; mword = '0; mc = 1'b0; merr = 1'b0;
      end else begin
        if (start && (mk > 0 || (mh && !out_ready))) merr = 1'b1;
        if (start && mk == 0 && (!mh || out_ready)) begin
          macc = {7'd0, sum}; mk = 1; mh = 1'b0;
        end else if (mk > 0) begin
          macc = macc | (8'(sum) << mk);
          mk++;
          if (mk == 8) begin
            mk = 0; mh = 1'b1; mword = macc; mc = carry;
          end
        end else if (mh && out_ready) begin
          mh = 1'b0;
        end
      end
      step();
      check("rnd_valid", 32'(out_valid), 32'(mh));
      check("rnd_busy", 32'(busy), 32'(mk > 0));
      check("rnd_err", 32'(err), 32'(merr));
      if (mh || r_rst) begin
        check("rnd_result", 32'(result), 32'(mword));
        check("rnd_carry", 32'(carry_out), 32'(mc));
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_sum_collector.md
SERIAL_SUM_COLLECTOR -- requirements
Module: serial_sum_collector

Interface
REQ-001 Parameter: WIDTH, default 8, result word width in bits; legal range WIDTH >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  frame marker; high for one cycle, coincident with sum bit 0 (LSB) of a frame.
REQ-005 Port: sum  input  1  serial sum bit from the upstream Moore serial adder, LSB first, one bit per cycle.
REQ-006 Port: carry  input  1  adder carry state; sampled only with the last bit of a frame.
REQ-007 Port: out_ready  input  1  downstream consumer accepts the result word.
REQ-008 Port: result  output  WIDTH  assembled sum word, bit 0 = first serial bit.
REQ-009 Port: carry_out  output  1  final carry of the frame (bit WIDTH of the full sum).
REQ-010 Port: out_valid  output  1  result and carry_out valid, held until accepted.
REQ-011 Port: busy  output  1  high while a frame is being collected.
REQ-012 Port: err  output  1  sticky protocol-error flag.

Function
REQ-013 The FSM SHALL have the states IDLE, COLLECT and HOLD, with all outputs decoded from registered state and datapath registers only (Moore style, no combinational input-to-output path).
REQ-014 IDLE: if start=1, the block SHALL capture sum as bit 0, set the bit counter to 1 and move to COLLECT; otherwise it SHALL stay in IDLE and ignore sum/carry.
REQ-015 COLLECT: each cycle the block SHALL shift sum into the shift register (shift right, new bit enters at MSB) and increment the counter.
REQ-016 When the counter equals WIDTH-1 in COLLECT, the block SHALL capture the last bit, latch carry into carry_out and move to HOLD.
REQ-017 Latency: with start at cycle N, out_valid SHALL rise at cycle N+WIDTH, with result[i] equal to the sum bit presented at cycle N+i.
REQ-018 HOLD: out_valid=1; result and carry_out SHALL remain stable until the handshake out_valid && out_ready completes.
REQ-019 HOLD with out_ready=1 and start=0: the block SHALL go to IDLE and drop out_valid on the next cycle.
REQ-020 HOLD with out_ready=1 and start=1 in the same cycle: the block SHALL complete the handshake and begin the new frame (capture bit 0, counter=1, state COLLECT); no bubble.
REQ-021 HOLD with out_ready=0 and start=1: the block SHALL drop the new frame, keep the held result unchanged and set err.
REQ-022 start=1 during COLLECT: the block SHALL ignore it (frame continues unchanged) and set err.
REQ-023 busy SHALL be 1 exactly in COLLECT, and 0 in IDLE and HOLD.
REQ-024 err SHALL stay set until rst.
REQ-025 The counter SHALL be ceil(log2(WIDTH)) bits wide (minimum 1) and SHALL never exceed WIDTH-1.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL force state IDLE, counter 0, result 0, carry_out 0, out_valid 0, busy 0 and err 0, overriding all other inputs including start.
REQ-027 Reset asserted mid-frame SHALL discard the partial word; the first start after rst deasserts SHALL begin a clean frame.

Verification (WIDTH=8)
REQ-028 0x5A+0x3C: start at cycle N, sum bits 0,1,1,0,1,0,0,1, carry=0 on the last bit -> out_valid at N+8, result=0x96, carry_out=0.
REQ-029 0xFF+0x01: sum bits all 0, carry=1 on the last bit -> result=0x00, carry_out=1.
REQ-030 Backpressure: out_ready=0 for 5 cycles after out_valid -> result and carry_out stable, out_valid held; the handshake completes on the first cycle out_ready=1, and out_valid=0 on the next cycle.
REQ-031 Back-to-back: out_ready=1 and start=1 in the same HOLD cycle -> the second frame (0x01+0x02) yields result=0x03 exactly 8 cycles later, err=0.
REQ-032 Protocol errors: start during bit 3 of a frame -> frame result unaffected, err=1. Separately, start in HOLD with out_ready=0 -> held word unchanged, err=1.
REQ-033 Reset mid-frame: rst after 4 bits -> all outputs 0 on the next cycle; a following full frame 0x12 collects correctly.
